// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial WIDTH-bit subtractor (A - B - borrow-in),
//                     one bit per clock LSB first, start/busy/done handshake.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  input  logic             i_borrow,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  localparam int unsigned      c_cnt_w = $clog2(WIDTH) + 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_diff;
  logic               r_brw;
  logic [c_cnt_w-1:0] r_cnt;

  logic w_accept;
  logic w_last;
  logic w_bit_a;
  logic w_bit_b;
  logic w_d;
  logic w_brw_next;

  // A new operation may only be taken when no bits are in flight.
  assign w_accept = i_start && (r_state != S_RUN);
  assign w_last   = (r_cnt == c_last);

  assign w_bit_a    = r_a[0];
  assign w_bit_b    = r_b[0];
  assign w_d        = w_bit_a ^ w_bit_b ^ r_brw;
  assign w_brw_next = (~w_bit_a & w_bit_b) | (~(w_bit_a ^ w_bit_b) & r_brw);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = i_start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Result and borrow only move on accept or while running, so they hold
  // through DONE and the following idle period.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_diff <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a   <= i_minuend;
      r_b   <= i_subtrahend;
      r_brw <= i_borrow;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a    <= r_a >> 1;
      r_b    <= r_b >> 1;
      r_diff <= {w_d, r_diff[WIDTH-1:1]};
      r_brw  <= w_brw_next;
      r_cnt  <= r_cnt + c_cnt_w'(1);
    end
  end

  assign o_busy   = (r_state == S_RUN);
  assign o_done   = (r_state == S_DONE);
  assign o_diff   = r_diff;
  assign o_borrow = r_brw;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : directed self-checking bench for serial_subtractor
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // WIDTH=8 instance
  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;

  // WIDTH=4 instance
  logic       start4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, borrow4;
  logic [3:0] diff4;

  // WIDTH=32 instance
  logic        start32 = 1'b0, bin32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, borrow32;
  logic [31:0] diff32;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_minuend(a8),
    .i_subtrahend(b8), .i_borrow(bin8), .o_busy(busy8), .o_done(done8),
    .o_diff(diff8), .o_borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_minuend(a4),
    .i_subtrahend(b4), .i_borrow(bin4), .o_busy(busy4), .o_done(done4),
    .o_diff(diff4), .o_borrow(borrow4)
  );

  serial_subtractor #(.WIDTH(32)) u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_start(start32), .i_minuend(a32),
    .i_subtrahend(b32), .i_borrow(bin32), .o_busy(busy32), .o_done(done32),
    .o_diff(diff32), .o_borrow(borrow32)
  );

  // Launch one operation and wait (bounded) for done; lat = -1 on timeout.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      output logic [7:0] d, output logic bo, output int lat,
                      output int busy_n);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = -1; busy_n = 0; d = '0; bo = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy8) busy_n++;
      if (done8) begin
        lat = n - 1; d = diff8; bo = borrow8;
        break;
      end
    end
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                      output logic [3:0] d, output logic bo, output int lat);
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; bin4 = bin;
    @(posedge clk);
    #1 start4 = 1'b0;
    lat = -1; d = '0; bo = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done4) begin
        lat = n - 1; d = diff4; bo = borrow4;
        break;
      end
    end
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic bin,
                       output logic [31:0] d, output logic bo, output int lat);
    @(negedge clk);
    start32 = 1'b1; a32 = a; b32 = b; bin32 = bin;
    @(posedge clk);
    #1 start32 = 1'b0;
    lat = -1; d = '0; bo = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done32) begin
        lat = n - 1; d = diff32; bo = borrow32;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
      failures++;
      $display("FAIL reset_active8 got busy=%0b done=%0b diff=%h brw=%0b want all 0",
               busy8, done8, diff8, borrow8);
    end
    checks++;
    if ({busy4, done4, diff4, borrow4, busy32, done32, diff32, borrow32} !== 42'd0) begin
      failures++;
      $display("FAIL reset_active_w4_w32 got diff4=%h diff32=%h want 0", diff4, diff32);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
      failures++;
      $display("FAIL reset_idle8 got busy=%0b done=%0b diff=%h brw=%0b want all 0",
               busy8, done8, diff8, borrow8);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d; logic bo; int lat, bn;
    run8(8'h5A, 8'h3C, 1'b0, d, bo, lat, bn);
    checks++;
    if (lat !== 8) begin
      failures++; $display("FAIL basic_latency got %0d want 8", lat);
    end
    checks++;
    if (bn !== 8) begin
      failures++; $display("FAIL basic_busy_cycles got %0d want 8", bn);
    end
    checks++;
    if ({d, bo} !== {8'h1E, 1'b0}) begin
      failures++; $display("FAIL basic_result got %h/%0b want 1e/0", d, bo);
    end
    checks++;
    if (busy8 !== 1'b0) begin
      failures++; $display("FAIL basic_busy_in_done got %0b want 0", busy8);
    end
    @(negedge clk);
    checks++;
    if ({done8, busy8} !== 2'b00) begin
      failures++; $display("FAIL basic_done_pulse got done=%0b busy=%0b want 0/0", done8, busy8);
    end
  endtask

  task automatic test_underflow();
    logic [7:0] d; logic bo; int lat, bn;
    run8(8'h00, 8'h01, 1'b0, d, bo, lat, bn);
    checks++;
    if ({d, bo} !== {8'hFF, 1'b1} || lat !== 8) begin
      failures++; $display("FAIL underflow_0_1 got %h/%0b lat=%0d want ff/1 lat=8", d, bo, lat);
    end
    run8(8'h10, 8'h10, 1'b1, d, bo, lat, bn);
    checks++;
    if ({d, bo} !== {8'hFF, 1'b1} || lat !== 8) begin
      failures++; $display("FAIL underflow_bin got %h/%0b lat=%0d want ff/1 lat=8", d, bo, lat);
    end
  endtask

  task automatic test_back_to_back();
    int first_idx = -1, second_idx = -1, pulses = 0;
    logic [7:0] d1 = '0, d2 = '0;
    logic b1 = 1'b0, b2 = 1'b0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h0F; bin8 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 3) begin
        a8 = 8'h80; b8 = 8'h01;
      end
      if (done8) begin
        pulses++;
        if (first_idx < 0) begin
          first_idx = n; d1 = diff8; b1 = borrow8;
        end else begin
          second_idx = n; d2 = diff8; b2 = borrow8;
          start8 = 1'b0;
          break;
        end
      end
    end
    start8 = 1'b0;
    checks++;
    if (first_idx !== 9) begin
      failures++; $display("FAIL b2b_first_done_cycle got %0d want 9", first_idx);
    end
    checks++;
    if ({d1, b1} !== {8'hF0, 1'b0}) begin
      failures++; $display("FAIL b2b_first_result got %h/%0b want f0/0", d1, b1);
    end
    checks++;
    if (second_idx - first_idx !== 9) begin
      failures++; $display("FAIL b2b_period got %0d want 9", second_idx - first_idx);
    end
    checks++;
    if ({d2, b2} !== {8'h7F, 1'b0}) begin
      failures++; $display("FAIL b2b_second_result got %h/%0b want 7f/0", d2, b2);
    end
    checks++;
    if (pulses !== 2) begin
      failures++; $display("FAIL b2b_pulse_count got %0d want 2", pulses);
    end
    @(negedge clk);
    checks++;
    if ({busy8, done8} !== 2'b00) begin
      failures++; $display("FAIL b2b_return_idle got busy=%0b done=%0b want 0/0", busy8, done8);
    end
  endtask

  task automatic test_reset_mid_run();
    int spurious = 0;
    logic [7:0] d; logic bo; int lat, bn;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hC3; b8 = 8'h21; bin8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy8 !== 1'b1) begin
      failures++; $display("FAIL rst_mid_busy_before got %0b want 1", busy8);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
      failures++;
      $display("FAIL rst_mid_async got busy=%0b done=%0b diff=%h brw=%0b want all 0",
               busy8, done8, diff8, borrow8);
    end
    @(negedge clk) rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done8 || busy8) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      failures++; $display("FAIL rst_mid_no_done got %0d active cycles want 0", spurious);
    end
    run8(8'h05, 8'h03, 1'b0, d, bo, lat, bn);
    checks++;
    if ({d, bo} !== {8'h02, 1'b0} || lat !== 8) begin
      failures++; $display("FAIL rst_mid_restart got %h/%0b lat=%0d want 02/0 lat=8", d, bo, lat);
    end
  endtask

  // Runs right after test_reset_mid_run, whose last result was 0x02/0.
  task automatic test_hold();
    for (int n = 0; n < 20; n++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({diff8, borrow8, busy8} !== {8'h02, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL hold_cycle%0d got diff=%h brw=%0b busy=%0b want 02/0/0",
                 n, diff8, borrow8, busy8);
      end
    end
  endtask

  task automatic test_exhaustive_w4();
    logic [3:0] d; logic bo; int lat;
    int exp_d, exp_b;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          run4(4'(a), 4'(b), 1'(c), d, bo, lat);
          exp_d = (a - b - c) & 15;
          exp_b = (a < b + c) ? 1 : 0;
          checks++;
          if (d !== 4'(exp_d) || bo !== 1'(exp_b) || lat !== 4) begin
            failures++;
            $display("FAIL w4 %0d-%0d-%0d got %h/%0b lat=%0d want %h/%0b lat=4",
                     a, b, c, d, bo, lat, exp_d, exp_b);
          end
        end
      end
    end
  endtask

  task automatic test_random_w32();
    logic [31:0] a, b, d; logic bin, bo; int lat;
    logic [32:0] exp;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom; b = $urandom; bin = 1'($urandom);
      if (n == 0) begin a = 32'h0; b = 32'hFFFF_FFFF; bin = 1'b1; end
      if (n == 1) begin a = 32'hFFFF_FFFF; b = 32'h0; bin = 1'b0; end
      run32(a, b, bin, d, bo, lat);
      exp = {1'b0, a} - {1'b0, b} - {32'd0, bin};
      checks++;
      if (d !== exp[31:0] || bo !== exp[32] || lat !== 32) begin
        failures++;
        $display("FAIL w32 %h-%h-%0b got %h/%0b lat=%0d want %h/%0b lat=32",
                 a, b, bin, d, bo, lat, exp[31:0], exp[32]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_back_to_back();
    test_reset_mid_run();
    test_hold();
    test_exhaustive_w4();
    test_random_w32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor that computes minuend − subtrahend − borrow-in one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the difference-side counterpart of our full-adder datapath cells. It serves area-constrained arithmetic paths where WIDTH-cycle latency is acceptable. A start/busy/done handshake sequences each operation.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  request a new operation; sampled only when the block can accept.
- i_minuend  input  WIDTH  operand A; captured on the accepting edge.
- i_subtrahend  input  WIDTH  operand B; captured on the accepting edge.
- i_borrow  input  1  borrow-in to bit 0; captured on the accepting edge.
- o_busy  output  1  high while bits are being processed (RUN state).
- o_done  output  1  single-cycle pulse: o_diff and o_borrow are valid.
- o_diff  output  WIDTH  A − B − borrow-in, modulo 2^WIDTH.
- o_borrow  output  1  borrow-out of the MSB; 1 when A < B + borrow-in (unsigned).

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Accepting states: IDLE and DONE. In either state, i_start=1 at an edge captures A, B and borrow-in into shift registers and the borrow flip-flop, clears the bit counter, and enters RUN.
- IDLE with i_start=0 stays in IDLE.
- DONE with i_start=0 goes to IDLE.
- RUN, each edge:
  - a = A[0], b = B[0].
  - d = a ^ b ^ brw.
  - brw_next = (~a & b) | (~(a ^ b) & brw).
  - d is shifted into the MSB of the result register. A and B shift right by one.
  - The counter increments.
- On the WIDTH-th RUN edge, state goes to DONE.
- After WIDTH shifts, the result register holds the full difference LSB-aligned, and brw holds the final borrow.
- o_diff and o_borrow are driven from registers. They are stable from DONE until the next accepting edge, including through the following IDLE period.
- During RUN, o_diff shows the partial shift contents and must not be used.
- i_start during RUN is ignored. Operands are not re-sampled, and no error is flagged.
- Operand inputs are don't-care except on the accepting edge.
- Reset asserted at any time, including mid-RUN or in DONE:
  - state goes to IDLE immediately (asynchronously);
  - o_busy=0, o_done=0, o_diff=0, o_borrow=0;
  - the counter and operand registers are cleared;
  - the in-flight operation is discarded, with no o_done.
- Bit counter width is clog2(WIDTH)+1.

## Timing
- Reset values: o_busy=0, o_done=0, o_diff=0, o_borrow=0.
- Accepting edge E0: o_busy rises after E0.
- o_busy stays high for exactly WIDTH cycles, edges E0+1 through E0+WIDTH.
- The RUN → DONE transition happens on edge E0+WIDTH. After that edge, o_busy=0, o_done=1 and results are valid. Start-to-result latency is WIDTH cycles.
- o_done is high for exactly one cycle.
- Back-to-back operation: i_start=1 during the DONE cycle is accepted on edge E0+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- No combinational path from any input to any output.

## Test plan
- Basic, WIDTH=8: start with A=0x5A, B=0x3C, borrow-in=0 → o_busy high for 8 cycles, then o_done pulses once with o_diff=0x1E, o_borrow=0.
- Underflow: A=0x00, B=0x01, borrow-in=0 → o_diff=0xFF, o_borrow=1. Then A=0x10, B=0x10, borrow-in=1 → o_diff=0xFF, o_borrow=1.
- Back-to-back and start ignored:
  - Hold i_start=1 continuously with A=0xFF, B=0x0F, borrow-in=0.
  - Change operands to A=0x80, B=0x01 mid-RUN.
  - Required: first o_done shows 0xF0/0; the second operation starts on the DONE edge with 0x80/0x01 and yields 0x7F/0.
  - o_done pulses exactly every 9 cycles.
- Reset mid-operation: assert i_rst asynchronously at RUN bit 4 → all outputs 0 immediately, no o_done follows. A new start with 0x05−0x03 afterwards gives 0x02/0.
- Exhaustive random: WIDTH=4, all 512 combinations of A, B and borrow-in → o_diff == (A−B−bin) mod 16 and o_borrow == (A < B+bin). Repeat with 1000 random vectors at WIDTH=32.
- Hold check: after o_done, idle 20 cycles with random operand inputs and i_start=0 → o_diff and o_borrow unchanged, o_busy=0.
